// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder: FSM state encoding and mode values.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec_n.sv
// Combinational SEL_W-to-2**SEL_W active-low one-hot decoder; all ones when disabled.
module onehot_dec_n #(
  parameter int SEL_W = 4
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [0:2**SEL_W-1] y_n
);

  always_comb begin
    y_n = '1;
    if (en) y_n[sel] = 1'b0;
  end

endmodule

// File: rtl/scan_decoder.sv
// Active-low one-hot select driver with direct decode and auto-scan (dwell timer, optional blank gap).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_OFF    | disabled; outputs all inactive, idx and dwell count frozen
// ST_DIRECT | y_n follows registered sel
// ST_SCAN   | y_n[idx] active; dwell count runs, advances idx at dwell
// ST_BLANK  | one all-inactive gap cycle after an advance (BLANK=1 only)
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8,
  parameter int BLANK   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [0:2**SEL_W-1] y_n,
  output logic [SEL_W-1:0]    idx,
  output logic                wrap
);

  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     idx_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;
  logic                 wrap_nxt;
  logic                 dec_en;
  logic [0:2**SEL_W-1]  dec_y_n;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
    if (!en) begin
      state_nxt = ST_OFF;
    end else if (mode == MODE_SCAN) begin
      case (state)
        ST_OFF: begin
          // resume: idx and count keep their frozen values
          state_nxt = ST_SCAN;
        end
        ST_DIRECT: begin
          state_nxt = ST_SCAN;
          idx_nxt   = sel;
          cnt_nxt   = '0;
        end
        ST_SCAN: begin
          if (cnt >= dwell) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + SEL_W'(1);
            wrap_nxt  = (idx == IDX_MAX);
            state_nxt = (BLANK != 0) ? ST_BLANK : ST_SCAN;
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
          end
        end
        ST_BLANK: begin
          state_nxt = ST_SCAN;
        end
        default: begin
          state_nxt = ST_OFF;
        end
      endcase
    end else begin
      state_nxt = ST_DIRECT;
      idx_nxt   = sel;
      cnt_nxt   = '0;
    end
  end

  // Decoder is fed from next-state values so y_n lines up with the registered idx/state.
  assign dec_en = (state_nxt == ST_DIRECT) || (state_nxt == ST_SCAN);

  onehot_dec_n #(
    .SEL_W (SEL_W)
  ) u_dec (
    .en  (dec_en),
    .sel (idx_nxt),
    .y_n (dec_y_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      idx   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
      y_n   <= '1;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
      y_n   <= dec_y_n;
    end
  end

endmodule
